// File: rtl/misao_mem_arbiter.sv
// misao_mem_arbiter
//   Shares the single byte-wide MISA-O memory port between two requesters.
//   Port 0 (core) has fixed priority; port 1 (debug loader / DMA) is granted
//   once port 0 has taken MAX_BURST consecutive grants while port 1 waits.
//   At most one access is issued per cycle. Issued reads are tracked through
//   an RD_LAT-deep owner-tag pipeline so each returned byte reaches its issuer.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   mX_req/we/addr/wdata  request from port X, held stable until mX_gnt
//   mX_gnt                access for port X issued this cycle (combinational)
//   mX_rvalid/rdata       read data for port X (rdata is 0 when rvalid is 0)
//   mem_enable_read/write read and write strobes to memory
//   mem_addr/rw/data_out  address, direction (1 = write), write data
//   mem_data_in           read data, RD_LAT cycles after the read is issued
module misao_mem_arbiter #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_enable_read,
  output logic              mem_enable_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in
);

  logic [3:0] burst_cnt;
  logic       burst_full;
  logic       win0;
  logic       win1;
  logic       push_v;
  logic       push_p;
  logic       out_v;
  logic       out_p;

  assign burst_full = (burst_cnt == 4'(MAX_BURST));

  // Grants are forced low while rst is high so no access leaks out of reset.
  assign win0   = m0_req & ~(m1_req & burst_full) & ~rst;
  assign win1   = m1_req & ~(m0_req & ~burst_full) & ~rst;
  assign m0_gnt = win0;
  assign m1_gnt = win1;

  always_comb begin
    mem_enable_read  = 1'b0;
    mem_enable_write = 1'b0;
    mem_addr         = '0;
    mem_data_out     = '0;
    if (win0) begin
      mem_enable_read  = ~m0_we;
      mem_enable_write = m0_we;
      mem_addr         = m0_addr;
      mem_data_out     = m0_wdata;
    end else if (win1) begin
      mem_enable_read  = ~m1_we;
      mem_enable_write = m1_we;
      mem_addr         = m1_addr;
      mem_data_out     = m1_wdata;
    end
  end

  assign mem_rw = mem_enable_write;

  // Owner tag of this cycle's access: valid only for reads, port = 1 for port 1.
  assign push_v = (win0 & ~m0_we) | (win1 & ~m1_we);
  assign push_p = win1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (!m1_req || win1) begin
      burst_cnt <= '0;
    end else if (win0 && !burst_full) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign out_v = push_v;
      assign out_p = push_p;
    end else begin : g_pipe
      logic [RD_LAT-1:0] tag_v;
      logic [RD_LAT-1:0] tag_p;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tag_v <= '0;
          tag_p <= '0;
        end else begin
          tag_v[0] <= push_v;
          tag_p[0] <= push_p;
          for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_p[i] <= tag_p[i-1];
          end
        end
      end

      assign out_v = tag_v[RD_LAT-1];
      assign out_p = tag_p[RD_LAT-1];
    end
  endgenerate

  assign m0_rvalid = out_v & ~out_p & ~rst;
  assign m1_rvalid = out_v & out_p & ~rst;
  assign m0_rdata  = m0_rvalid ? mem_data_in : '0;
  assign m1_rdata  = m1_rvalid ? mem_data_in : '0;

endmodule

// File: doc/misao_mem_arbiter.md
Name: misao_mem_arbiter

Overview:
- Shares the single byte-wide memory port of the MISA-O system between two requesters: port 0 is the misao core and port 1 is a secondary master (debug loader / DMA).
- Issues at most one memory access per cycle.
- Port 0 has fixed priority, limited by a fairness burst limit so port 1 cannot starve.
- Tracks outstanding reads through a latency pipeline and routes each returned byte to its issuer.

Parameters:
- ADDR_W, 15, memory address width (bytes).
- DATA_W, 8, data width.
- RD_LAT, 1, cycles from issue to read data on mem_data_in; legal 0..3.
- MAX_BURST, 4, max consecutive port-0 grants while port 1 is pending; legal 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- m0_req  in  1  port 0 access request.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  ADDR_W  port 0 address.
- m0_wdata  in  DATA_W  port 0 write data.
- m0_gnt  out  1  port 0 access issued this cycle.
- m0_rvalid  out  1  port 0 read data valid.
- m0_rdata  out  DATA_W  port 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1.
- mem_enable_read  out  1  read strobe to memory.
- mem_enable_write  out  1  write strobe; memory writes on the clk edge ending the cycle.
- mem_addr  out  ADDR_W  memory address.
- mem_rw  out  1  1 = write, 0 = read; equals mem_enable_write.
- mem_data_out  out  DATA_W  write data to memory.
- mem_data_in  in  DATA_W  read data from memory.

Behaviour:
- Handshake: a requester holds req/we/addr/wdata stable until it sees gnt in the same cycle. gnt is combinational from req and the registered arbitration state.
- Memory outputs are combinational from the winner.
  - No winner: all memory outputs are 0.
  - mem_enable_read = win & !we; mem_enable_write = win & we.
- Arbitration, per cycle:
  - Only one port requesting: that port wins.
  - Both requesting: port 1 wins if burst_cnt == MAX_BURST, else port 0 wins.
- burst_cnt (4-bit register):
  - m0_gnt while m1_req is high: increment, saturating at MAX_BURST.
  - m1_gnt, or m1_req low: clear to 0.
- Read pipeline:
  - Each issued read pushes an owner tag {valid, port} into an RD_LAT-deep shift register.
  - When a tag exits the pipeline: the owner's rvalid = 1 and its rdata = mem_data_in.
  - RD_LAT = 0: rvalid is asserted in the same cycle as gnt, and rdata is combinational from mem_data_in.
  - Writes push an invalid tag.
  - Back-to-back reads from alternating ports return in issue order, one per cycle.
- rdata while rvalid = 0 is 0.
- A cycle with no grant pushes an invalid tag; the pipeline always advances.
- Simultaneous events:
  - A new grant and a returning read in the same cycle are independent.
  - A port may get gnt and rvalid in the same cycle.
- Write followed by read of the same address in the next cycle returns the new data; the memory must provide this.
- Reset, asynchronous, any time:
  - burst_cnt = 0 and all pipeline tags invalid.
  - All gnt/rvalid/rdata/mem_* outputs are 0 while rst is high.
  - Reads in flight at reset never produce rvalid.
  - The first grant is possible in the first cycle after rst deasserts.
- Requests asserted during reset are held by the requester and serviced after reset.
- Arbitration and the pipeline are registers only. There is no FSM beyond burst_cnt and the tag pipeline.

Test Plan:
1. Port-0 reads only, RD_LAT=1, memory[3]=0x45, m0 reads addr 3 → m0_gnt same cycle, mem_enable_read=1, mem_addr=3; next cycle m0_rvalid=1, m0_rdata=0x45; m1 outputs stay 0.
2. Contention, MAX_BURST=4, both ports request reads continuously → grant sequence 0,0,0,0,1,0,0,0,0,1…; every read data is returned to the issuing port with the correct address contents.
3. Writes: m1 writes 0x5A to addr 0x20 while m0 idle → mem_enable_write=1, mem_rw=1, mem_data_out=0x5A, no rvalid; then m0 reads 0x20 → 0x5A.
4. RD_LAT=2, interleaved m0 read addr 1 (0x11) and m1 read addr 2 (0x22) on consecutive cycles → m0_rvalid with 0x11 two cycles after its gnt, m1_rvalid with 0x22 one cycle later; no cross-delivery.
5. RD_LAT=0 with the combinational memory model → m0_rvalid and m0_rdata match memory[addr] in the grant cycle, matching core fetch timing.
6. rst pulse with two reads in flight (RD_LAT=2) → all outputs 0 immediately; no rvalid after release; held m0 request is granted in the first cycle after release, with burst_cnt starting at 0.
